// File: rtl/piso_bit_feeder_if.sv
// Parallel-word input handshake and serial output bundle for piso_bit_feeder.
interface piso_bit_feeder_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;
  logic [15:0]      words_sent;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  word_done,
    input  words_sent
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_out,
    output ser_valid,
    output word_done,
    output words_sent
  );
endinterface

// File: rtl/piso_bit_feeder.sv
// Parallel-in serial-out feeder, MSB first, back-to-back capable.
// Define PISO_PARITY_EN to append an even-parity bit after each word's LSB.
module piso_bit_feeder #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  piso_bit_feeder_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
  logic [15:0]      words_sent_q, words_sent_d;
  logic             last_data_bit;
  logic             final_cycle;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  assign last_data_bit = (state_q == StShift) && (cnt_q == CntW'(WIDTH - 1));

`ifdef PISO_PARITY_EN
  assign final_cycle = (state_q == StParity);
`else
  assign final_cycle = last_data_bit;
`endif

  // Ready depends only on state/counter so upstream may wait on it.
  assign bus.in_ready = !rst && ((state_q == StIdle) || final_cycle);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    word_done_d = 1'b0;
`ifdef PISO_PARITY_EN
    par_d       = par_q;
`endif
    unique case (state_q)
      StIdle: ;
      StShift: begin
        if (!last_data_bit) begin
          // sreg_q[WIDTH-1] is the bit on the wire now; the next one sits below it.
          cnt_d       = cnt_q + 1'b1;
          sreg_d      = sreg_q << 1;
          ser_out_d   = sreg_q[WIDTH-2];
          ser_valid_d = 1'b1;
`ifndef PISO_PARITY_EN
          word_done_d = (cnt_q == CntW'(WIDTH - 2));
`endif
        end else begin
`ifdef PISO_PARITY_EN
          state_d     = StParity;
          ser_out_d   = par_q;
          ser_valid_d = 1'b1;
          word_done_d = 1'b1;
`else
          state_d     = StIdle;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      StParity: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d     = StShift;
      cnt_d       = '0;
      sreg_d      = bus.in_data;
      ser_out_d   = bus.in_data[WIDTH-1];
      ser_valid_d = 1'b1;
      word_done_d = 1'b0;
`ifdef PISO_PARITY_EN
      par_d       = ^bus.in_data;
`endif
    end

    words_sent_d = words_sent_q + 16'(word_done_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sreg_q       <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      word_done_q  <= 1'b0;
      words_sent_q <= '0;
`ifdef PISO_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sreg_q       <= sreg_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      word_done_q  <= word_done_d;
      words_sent_q <= words_sent_d;
`ifdef PISO_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.word_done  = word_done_q;
  assign bus.words_sent = words_sent_q;

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Scoreboard bench for piso_bit_feeder: accepted words expand into expected bit streams.
module tb_piso_bit_feeder;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic b;
    logic last;
  } exp_bit_t;

  logic clk;
  logic rst;
  piso_bit_feeder_if #(.WIDTH(W)) bus ();

  piso_bit_feeder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_bit_t    exp_q[$];
  logic [15:0] model_cnt;
  logic        model_ready;
  int          n_cmp;
  int          n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard push: an accepted word becomes its MSB-first bit list.
  always @(posedge clk) begin
    if (!rst && bus.in_valid && model_ready) begin
      logic [W-1:0] w;
      w = bus.in_data;
      for (int i = W - 1; i >= 0; i--) begin
`ifdef PISO_PARITY_EN
        exp_q.push_back('{b: w[i], last: 1'b0});
`else
        exp_q.push_back('{b: w[i], last: (i == 0)});
`endif
      end
`ifdef PISO_PARITY_EN
      exp_q.push_back('{b: ^w, last: 1'b1});
`endif
      model_ready = 1'b0;
    end
  end

  // Monitor: one expected bit per output cycle.
  always @(negedge clk) begin
    exp_bit_t e;
    if (rst) begin
      exp_q.delete();
      model_cnt   = '0;
      model_ready = 1'b0;
      check("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
      check("rst_ser_out", 32'(bus.ser_out), 32'd0);
      check("rst_word_done", 32'(bus.word_done), 32'd0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ser_valid", 32'(bus.ser_valid), 32'd1);
      check("ser_out", 32'(bus.ser_out), 32'(e.b));
      check("word_done", 32'(bus.word_done), 32'(e.last));
      if (e.last) model_cnt = model_cnt + 16'd1;
    end else begin
      check("idle_ser_valid", 32'(bus.ser_valid), 32'd0);
      check("idle_ser_out", 32'(bus.ser_out), 32'd0);
      check("idle_word_done", 32'(bus.word_done), 32'd0);
    end
    if (!rst) model_ready = (exp_q.size() == 0);
    check("in_ready", 32'(bus.in_ready), 32'(model_ready));
    check("words_sent", 32'(bus.words_sent), 32'(model_cnt));
  end

  // Hold in_valid with word w until the model says it was taken.
  task automatic send_word(input logic [W-1:0] w);
    bit taken;
    taken        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 4 * W + 8; i++) begin
      @(negedge clk);
      #1;
      if (model_ready) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    model_cnt    = '0;
    model_ready  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word, then two back-to-back words.
    send_word(8'hA5);
    idle_cycles(W + 4);
    send_word(8'hA5);
    send_word(8'h3C);
    idle_cycles(2 * W + 4);

    // Data churn while a word is in flight must not disturb it.
    send_word(8'h5A);
    for (int i = 0; i < W - 2; i++) begin
      bus.in_data = (i % 2 == 0) ? 8'h00 : 8'hFF;
      @(posedge clk);
      #1;
    end
    idle_cycles(3 * W);

    send_word(8'h07);
    idle_cycles(W + 4);

    // Reset mid-word: drop the partial word.
    send_word(8'hA5);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    idle_cycles(3);

    // Random traffic with arbitrary data on every cycle.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = W'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;

    begin
      bit drained;
      drained = 1'b0;
      for (int i = 0; i < 4 * W; i++) begin
        @(negedge clk);
        #1;
        if (exp_q.size() == 0) begin
          drained = 1'b1;
          break;
        end
      end
      if (!drained) check("drain_timeout", 32'd0, 32'd1);
    end
    idle_cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
